// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, opcode constants and decode helpers.
package cpu_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH_OP  = 3'd1;
    localparam logic [2:0] ST_ADV_OP    = 3'd2;
    localparam logic [2:0] ST_FETCH_ARG = 3'd3;
    localparam logic [2:0] ST_ADV_ARG   = 3'd4;
    localparam logic [2:0] ST_JUMP      = 3'd5;
    localparam logic [2:0] ST_ISSUE     = 3'd6;
    localparam logic [2:0] ST_HALT      = 3'd7;

    localparam logic [7:0] HLT_OP_DEFAULT   = 8'hFF;
    localparam int         LONG_BIT_DEFAULT = 7;
    localparam logic [1:0] JUMP_PREFIX      = 2'b11;
    localparam logic [7:0] NO_OPERAND       = 8'h00;

    function automatic logic is_long_op(input logic [7:0] op, input logic [2:0] long_idx);
        return op[long_idx];
    endfunction

    // A halt opcode also carries the jump prefix by default, so it is excluded explicitly.
    function automatic logic is_jump_op(input logic [7:0] op, input logic [7:0] hlt_op);
        return (op[7:6] == JUMP_PREFIX) && (op != hlt_op);
    endfunction

endpackage

// File: rtl/pc_adv_seq.sv
// Two-cycle LDPC pulse generator: the PC steps only after LDPC is seen on two consecutive edges.
module pc_adv_seq (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    output logic done,
    output logic LDPC
);

    logic cnt_q;
    logic cnt_d;

    always_comb begin
        cnt_d = 1'b0;
        if (start) begin
            cnt_d = ~cnt_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign LDPC = start;
    assign done = start & cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch / IR stage: fetches 1- or 2-byte instructions over ROM req/ack, steps the PC, redirects on jumps.
// Build option: define IR_JUMP_EN to compile in jump decoding and the JUMP state.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [7:0] HLT_OP   = HLT_OP_DEFAULT,
    parameter int         LONG_BIT = LONG_BIT_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       run,
    input  logic [7:0] ABUSI,
    output logic       LDPC,
    output logic       LOAD,
    output logic [7:0] load_addr,
    output logic [7:0] rom_addr,
    output logic       rom_req,
    input  logic       rom_ack,
    input  logic [7:0] rom_rdata,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [7:0] ir_opcode,
    output logic [7:0] ir_operand,
    output logic [7:0] ir_pc,
    output logic       halted,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] LONG_IDX = 3'(LONG_BIT);

    logic [2:0] state_q, state_d;
    logic [7:0] ir_opcode_q, ir_opcode_d;
    logic [7:0] ir_operand_q, ir_operand_d;
    logic [7:0] ir_pc_q, ir_pc_d;
    logic       adv_start;
    logic       adv_done;
    logic       take_jump;

    assign adv_start = (state_q == ST_ADV_OP) || (state_q == ST_ADV_ARG);

    pc_adv_seq u_pc_adv_seq (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (adv_start),
        .done    (adv_done),
        .LDPC    (LDPC)
    );

`ifdef IR_JUMP_EN
    assign take_jump = is_jump_op(ir_opcode_q, HLT_OP);
`else
    assign take_jump = 1'b0;
`endif

    // IR handshake: ir_valid stays high with ir_* frozen until ir_ready; the
    // transfer happens on the rising edge where ir_valid and ir_ready are both 1.
    always_comb begin
        state_d      = state_q;
        ir_opcode_d  = ir_opcode_q;
        ir_operand_d = ir_operand_q;
        ir_pc_d      = ir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (rom_ack) begin
                    ir_opcode_d  = rom_rdata;
                    ir_operand_d = NO_OPERAND;
                    ir_pc_d      = ABUSI;
                    state_d      = ST_ADV_OP;
                end
            end
            ST_ADV_OP: begin
                if (adv_done) begin
                    if (ir_opcode_q == HLT_OP) begin
                        state_d = ST_HALT;
                    end else if (is_long_op(ir_opcode_q, LONG_IDX)) begin
                        state_d = ST_FETCH_ARG;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FETCH_ARG: begin
                if (rom_ack) begin
                    ir_operand_d = rom_rdata;
                    state_d      = ST_ADV_ARG;
                end
            end
            ST_ADV_ARG: begin
                if (adv_done) begin
                    state_d = take_jump ? ST_JUMP : ST_ISSUE;
                end
            end
            ST_JUMP: begin
                state_d = run ? ST_FETCH_OP : ST_IDLE;
            end
            ST_ISSUE: begin
                if (ir_ready) begin
                    state_d = run ? ST_FETCH_OP : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= ST_IDLE;
            ir_opcode_q  <= 8'h00;
            ir_operand_q <= 8'h00;
            ir_pc_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            ir_opcode_q  <= ir_opcode_d;
            ir_operand_q <= ir_operand_d;
            ir_pc_q      <= ir_pc_d;
        end
    end

    assign rom_addr   = ABUSI;
    assign rom_req    = (state_q == ST_FETCH_OP) || (state_q == ST_FETCH_ARG);
    assign ir_valid   = (state_q == ST_ISSUE);
    assign halted     = (state_q == ST_HALT);
    assign ir_opcode  = ir_opcode_q;
    assign ir_operand = ir_operand_q;
    assign ir_pc      = ir_pc_q;
    assign dbg_state  = state_q;

`ifdef IR_JUMP_EN
    assign LOAD      = (state_q == ST_JUMP);
    assign load_addr = LOAD ? ir_operand_q : 8'h00;
`else
    assign LOAD      = 1'b0;
    assign load_addr = 8'h00;
`endif

endmodule
